seven_seg_scanner: RTL



---
 rtl/seven_seg_pkg.sv | 31 +++
 rtl/seven_seg_scanner_if.sv | 33 +++
 rtl/seven_seg_scanner_hex_to_seg.sv | 35 +++
 rtl/seven_seg_scanner.sv | 137 +++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared constants for the seven-segment scanner slice.
// Provides the digit count, the segment bus width, the active-high hex
// segment patterns ({g,f,e,d,c,b,a}) and the slot-length helper.
package seven_seg_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int SEG_W      = 7;

  localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_A = 7'h77;
  localparam logic [SEG_W-1:0] SEG_B = 7'h7C;
  localparam logic [SEG_W-1:0] SEG_C = 7'h39;
  localparam logic [SEG_W-1:0] SEG_D = 7'h5E;
  localparam logic [SEG_W-1:0] SEG_E = 7'h79;
  localparam logic [SEG_W-1:0] SEG_F = 7'h71;

  // Clock cycles spent on one digit slot.
  function automatic int digit_cycles(input int freq_hz, input int scan_hz);
    return freq_hz / scan_hz;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// seven_seg_scanner_if: display data in / board pins out.
//   value        32  packed digits, digit i = value[4i+3:4i]
//   digit_enable  8  bit i = digit i shown
//   dp_enable     8  bit i = decimal point of digit i shown
//   brightness    4  0 = dimmest, 15 = full slot
//   anode         8  digit select (pin polarity)
//   cathode       7  segments {g,f,e,d,c,b,a} (pin polarity)
//   dp            1  decimal point segment (pin polarity)
//   frame_start   1  one-cycle pulse at the first output cycle of digit 0
// master = data source (stopwatch / bench), slave = scanner.
interface seven_seg_scanner_if;
  import seven_seg_pkg::*;

  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   digit_enable;
  logic [NUM_DIGITS-1:0]   dp_enable;
  logic [3:0]              brightness;
  logic [NUM_DIGITS-1:0]   anode;
  logic [SEG_W-1:0]        cathode;
  logic                    dp;
  logic                    frame_start;

  modport master (
    output value, digit_enable, dp_enable, brightness,
    input  anode, cathode, dp, frame_start
  );

  modport slave (
    input  value, digit_enable, dp_enable, brightness,
    output anode, cathode, dp, frame_start
  );

endinterface

// File: rtl/seven_seg_scanner_hex_to_seg.sv
// hex_to_seg: combinational hex digit to active-high segment decoder.
//   hex_i  4  digit value 0..F
//   seg_o  7  segments {g,f,e,d,c,b,a}, 1 = lit
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0]       hex_i,
  output logic [SEG_W-1:0] seg_o
);

  // Hex digit to segment pattern lookup
  always_comb begin
    seg_o = {SEG_W{1'b0}};
    case (hex_i)
      4'h0:    seg_o = SEG_0;
      4'h1:    seg_o = SEG_1;
      4'h2:    seg_o = SEG_2;
      4'h3:    seg_o = SEG_3;
      4'h4:    seg_o = SEG_4;
      4'h5:    seg_o = SEG_5;
      4'h6:    seg_o = SEG_6;
      4'h7:    seg_o = SEG_7;
      4'h8:    seg_o = SEG_8;
      4'h9:    seg_o = SEG_9;
      4'hA:    seg_o = SEG_A;
      4'hB:    seg_o = SEG_B;
      4'hC:    seg_o = SEG_C;
      4'hD:    seg_o = SEG_D;
      4'hE:    seg_o = SEG_E;
      4'hF:    seg_o = SEG_F;
      default: seg_o = {SEG_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexes 8 hex digits onto a common-anode
// seven-segment display with per-frame input snapshot, leading guard
// (all-off) cycles in every slot and 16-level brightness PWM.
//   clk      clock
//   resetn   synchronous active-low reset
//   disp_if  slave side of seven_seg_scanner_if (data in, pins out)
// Outputs are registered; pin polarity is applied after the register.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int FREQ_HZ      = 100000000,
  parameter int SCAN_HZ      = 1000,
  parameter int GUARD_CYCLES = 2,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input logic                 clk,
  input logic                 resetn,
  seven_seg_scanner_if.slave  disp_if
);

  localparam int DIGIT_CYCLES = digit_cycles(FREQ_HZ, SCAN_HZ);
  localparam int SUB          = DIGIT_CYCLES / 16;
  localparam int CNT_W        = $clog2(DIGIT_CYCLES);
  localparam int DIG_W        = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [DIG_W-1:0] LAST_DIG  = DIG_W'(NUM_DIGITS - 1);

  // The 16-step PWM needs whole sub-slots of at least two cycles.
  if ((DIGIT_CYCLES < 32) || ((DIGIT_CYCLES % 16) != 0)) begin : g_bad_digit_cycles
    $error("seven_seg_scanner: FREQ_HZ/SCAN_HZ must be >= 32 and a multiple of 16");
  end

  logic [CNT_W-1:0]        tick_q, tick_d;
  logic [DIG_W-1:0]        digit_q, digit_d;
  logic [4*NUM_DIGITS-1:0] val_snap_q;
  logic [NUM_DIGITS-1:0]   en_snap_q;
  logic [NUM_DIGITS-1:0]   dp_snap_q;
  logic [3:0]              bright_snap_q;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [SEG_W-1:0]        cathode_q, cathode_d;
  logic                    dp_q, dp_d;
  logic                    frame_start_q, frame_start_d;

  logic                    snap_load_s;
  logic [31:0]             tick_ext_s;
  logic [31:0]             on_cycles_s;
  logic                    lit_s;
  logic [3:0]              nibble_s;
  logic [SEG_W-1:0]        seg_s;

  // Snapshot on the last cycle of the frame so the next frame is coherent.
  assign snap_load_s = (digit_q == LAST_DIG) && (tick_q == LAST_TICK);
  assign tick_ext_s  = {{(32-CNT_W){1'b0}}, tick_q};
  assign on_cycles_s = ({28'd0, bright_snap_q} + 32'd1) * 32'(SUB);
  // With GUARD_CYCLES >= SUB, brightness 0 blanks the slot entirely.
  assign lit_s       = en_snap_q[digit_q]
                     && (tick_ext_s >= 32'(GUARD_CYCLES))
                     && (tick_ext_s < on_cycles_s);
  assign nibble_s    = val_snap_q[{digit_q, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .hex_i (nibble_s),
    .seg_o (seg_s)
  );

  // Slot tick and digit index next state
  always_comb begin
    tick_d  = tick_q;
    digit_d = digit_q;
    if (tick_q == LAST_TICK) begin
      tick_d  = {CNT_W{1'b0}};
      digit_d = digit_q + {{(DIG_W-1){1'b0}}, 1'b1};
    end else begin
      tick_d  = tick_q + {{(CNT_W-1){1'b0}}, 1'b1};
      digit_d = digit_q;
    end
  end

  // Active-high output pattern for the current (tick, digit)
  always_comb begin
    anode_d       = {NUM_DIGITS{1'b0}};
    cathode_d     = {SEG_W{1'b0}};
    dp_d          = 1'b0;
    frame_start_d = (digit_q == {DIG_W{1'b0}}) && (tick_q == {CNT_W{1'b0}});
    if (lit_s) begin
      anode_d[digit_q] = 1'b1;
      cathode_d        = seg_s;
      dp_d             = dp_snap_q[digit_q];
    end else begin
      anode_d   = {NUM_DIGITS{1'b0}};
      cathode_d = {SEG_W{1'b0}};
      dp_d      = 1'b0;
    end
  end

  // Scan counters
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tick_q  <= {CNT_W{1'b0}};
      digit_q <= {DIG_W{1'b0}};
    end else begin
      tick_q  <= tick_d;
      digit_q <= digit_d;
    end
  end

  // Input snapshot, also loaded throughout reset
  always_ff @(posedge clk) begin
    if (!resetn || snap_load_s) begin
      val_snap_q    <= disp_if.value;
      en_snap_q     <= disp_if.digit_enable;
      dp_snap_q     <= disp_if.dp_enable;
      bright_snap_q <= disp_if.brightness;
    end
  end

  // Output register (active-high internally)
  always_ff @(posedge clk) begin
    if (!resetn) begin
      anode_q       <= {NUM_DIGITS{1'b0}};
      cathode_q     <= {SEG_W{1'b0}};
      dp_q          <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      anode_q       <= anode_d;
      cathode_q     <= cathode_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign disp_if.anode       = ACTIVE_LOW ? ~anode_q   : anode_q;
  assign disp_if.cathode     = ACTIVE_LOW ? ~cathode_q : cathode_q;
  assign disp_if.dp          = ACTIVE_LOW ? ~dp_q      : dp_q;
  assign disp_if.frame_start = frame_start_q;

endmodule
